// File: rtl/sort_insert_stream.sv
// Sorted insert store: one-cycle parallel-rank insert while filling, ascending drain after flush.
// Define SORT_DROP_CNT_EN to add the saturating drop_cnt output.
module sort_insert_stream #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 100,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count,
  output logic             full
`ifdef SORT_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] e     [DEPTH];
  logic [WIDTH-1:0] e_ins [DEPTH];
  logic [DEPTH-1:0] le;
  logic             accept;
  logic             pop;

  assign out_data = e[0];
  assign full     = (count == CNT_W'(DEPTH));

  // le[i]: entry i is valid and not greater than the new word, so it stays put.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      le[i] = (CNT_W'(i) < count) && (e[i] <= in_data);
  end

  // The first position whose le bit drops takes in_data; everything above moves up.
  always_comb begin
    e_ins[0] = le[0] ? e[0] : in_data;
    for (int i = 1; i < DEPTH; i++)
      e_ins[i] = le[i] ? e[i] : (le[i-1] ? in_data : e[i-1]);
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == FILL);
    out_valid = (state == DRAIN) && (count != '0);
    accept    = in_valid && in_ready;
    pop       = out_valid && out_ready;
    case (state)
      FILL:    if (flush && ((count != '0) || accept)) state_nxt = DRAIN;
      DRAIN:   if ((count == '0) || (pop && (count == CNT_W'(1)))) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) e[i] <= '0;
    end else if (accept) begin
      // When full the top entry (or in_data itself, when ranked last) falls off.
      for (int i = 0; i < DEPTH; i++) e[i] <= e_ins[i];
      if (!full) count <= count + CNT_W'(1);
    end else if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) e[i] <= e[i+1];
      e[DEPTH-1] <= '0;
      count      <= count - CNT_W'(1);
    end
  end

`ifdef SORT_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                      drop_cnt <= '0;
    else if (accept && full && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sort_insert_stream.sv
// Directed table of per-cycle inputs and expected outputs for sort_insert_stream (DEPTH=4),
// plus a hand-written reset-override sequence.
module tb_sort_insert_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic [7:0]  count;
  logic        full;
`ifdef SORT_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  sort_insert_stream #(.WIDTH(16), .DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .full      (full)
`ifdef SORT_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  typedef struct {
    logic        rst, iv;
    logic [15:0] d;
    logic        fl, ordy;
    logic        x_ir, x_ov;
    logic [15:0] x_od;
    logic [7:0]  x_cnt;
    logic        x_full;
    logic        chk;
    logic        chk_drop;
    logic [15:0] x_drop;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic row(input logic r, input logic iv, input int d, input logic fl, input logic o,
                     input logic ir, input logic ov, input int od, input int c, input logic f);
    vec_t v;
    v.rst = r; v.iv = iv; v.d = 16'(d); v.fl = fl; v.ordy = o;
    v.x_ir = ir; v.x_ov = ov; v.x_od = 16'(od); v.x_cnt = 8'(c); v.x_full = f;
    v.chk = 1'b1; v.chk_drop = 1'b0; v.x_drop = '0;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;

    row(1,0,0,0,0, 0,0,0,0,0);  vecs[vecs.size()-1].chk = 1'b0;
    row(0,0,0,0,0, 1,0,0,0,0);  vecs[vecs.size()-1].chk_drop = 1'b1;
    // Insert 7,3,9,1 then flush and drain.
    row(0,1,7,0,0, 1,0,0,0,0);
    row(0,1,3,0,0, 1,0,7,1,0);
    row(0,1,9,0,0, 1,0,3,2,0);
    row(0,1,1,0,0, 1,0,3,3,0);
    row(0,0,0,1,1, 1,0,1,4,1);
    row(0,0,0,0,1, 0,1,1,4,1);
    row(0,0,0,0,1, 0,1,3,3,0);
    row(0,0,0,0,1, 0,1,7,2,0);
    row(0,0,0,0,1, 0,1,9,1,0);
    row(0,0,0,0,0, 1,0,0,0,0);
    // Full store: 5 displaces 9, 8 is dropped.
    row(0,1,1,0,0, 1,0,0,0,0);
    row(0,1,3,0,0, 1,0,1,1,0);
    row(0,1,7,0,0, 1,0,1,2,0);
    row(0,1,9,0,0, 1,0,1,3,0);
    row(0,1,5,0,0, 1,0,1,4,1);
    row(0,1,8,0,0, 1,0,1,4,1);
    row(0,0,0,1,0, 1,0,1,4,1);
    row(0,0,0,0,1, 0,1,1,4,1);
    row(0,0,0,0,1, 0,1,3,3,0);
    row(0,0,0,0,1, 0,1,5,2,0);
    row(0,0,0,0,1, 0,1,7,1,0);
    row(0,0,0,0,0, 1,0,0,0,0);  vecs[vecs.size()-1].chk_drop = 1'b1; vecs[vecs.size()-1].x_drop = 16'd2;
    // Duplicates with a stalling consumer.
    row(0,1,5,0,0, 1,0,0,0,0);
    row(0,1,5,0,0, 1,0,5,1,0);
    row(0,1,2,1,0, 1,0,5,2,0);
    row(0,0,0,0,1, 0,1,2,3,0);
    row(0,0,0,0,0, 0,1,5,2,0);
    row(0,0,0,0,1, 0,1,5,2,0);
    row(0,0,0,0,0, 0,1,5,1,0);
    row(0,0,0,0,1, 0,1,5,1,0);
    row(0,0,0,0,0, 1,0,0,0,0);
    // Flush on empty is ignored; flush with an insert drains that word.
    row(0,0,0,1,0, 1,0,0,0,0);
    row(0,0,0,0,0, 1,0,0,0,0);
    row(0,1,4,1,0, 1,0,0,0,0);
    row(0,0,0,0,1, 0,1,4,1,0);
    row(0,0,0,0,1, 1,0,0,0,0);
    row(0,0,0,0,0, 1,0,0,0,0);
    // Reset after two of four drain words.
    row(0,1,6,0,0, 1,0,0,0,0);
    row(0,1,2,0,0, 1,0,6,1,0);
    row(0,1,8,0,0, 1,0,2,2,0);
    row(0,1,4,0,0, 1,0,2,3,0);
    row(0,0,0,1,0, 1,0,2,4,1);
    row(0,0,0,0,1, 0,1,2,4,1);
    row(0,0,0,0,1, 0,1,4,3,0);
    row(1,0,0,0,1, 0,1,6,2,0);
    row(0,0,0,0,1, 1,0,0,0,0);  vecs[vecs.size()-1].chk_drop = 1'b1;
    row(0,0,0,0,1, 1,0,0,0,0);

    foreach (vecs[k]) begin
      if (k != 0) begin
        @(posedge clk);
        #1;
      end
      rst = vecs[k].rst; in_valid = vecs[k].iv; in_data = vecs[k].d;
      flush = vecs[k].fl; out_ready = vecs[k].ordy;
      @(negedge clk);
      if (vecs[k].chk) begin
        chk("in_ready",  k, 32'(in_ready),  32'(vecs[k].x_ir));
        chk("out_valid", k, 32'(out_valid), 32'(vecs[k].x_ov));
        chk("out_data",  k, 32'(out_data),  32'(vecs[k].x_od));
        chk("count",     k, 32'(count),     32'(vecs[k].x_cnt));
        chk("full",      k, 32'(full),      32'(vecs[k].x_full));
`ifdef SORT_DROP_CNT_EN
        if (vecs[k].chk_drop) chk("drop_cnt", k, 32'(drop_cnt), 32'(vecs[k].x_drop));
`endif
      end
    end

    // Reset overrides a simultaneous insert and flush.
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b1; in_data = 16'd7; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; in_data = 16'd3; flush = 1'b1;
    @(negedge clk);
    chk("pre_rst_count", 900, 32'(count), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("rst_ovr_count",     901, 32'(count),     32'd0);
    chk("rst_ovr_in_ready",  901, 32'(in_ready),  32'd1);
    chk("rst_ovr_out_valid", 901, 32'(out_valid), 32'd0);
    chk("rst_ovr_out_data",  901, 32'(out_data),  32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ovr_stay_fill", 902, 32'(in_ready),  32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
